// File: rtl/tcp_vlg_pkg.sv
// Shared TCP engine types: sequence/length numbers plus the RX streamer
// state encoding and the per-segment header captured at start of segment.
package tcp_vlg_pkg;

    typedef logic [31:0] tcp_num_t;
    typedef logic [15:0] length_t;

    typedef enum logic [1:0] {
        idle_s,
        strm_s,
        skip_s
    } rx_strm_state_t;

    typedef struct packed {
        tcp_num_t seq;
        length_t  lng;
    } tcp_rx_seg_t;

    // Modular distance from b forward to a in sequence space.
    function automatic tcp_num_t seq_dist(input tcp_num_t a, input tcp_num_t b);
        return a - b;
    endfunction

endpackage

// File: rtl/tcp_vlg_rx_strm_if.sv
// Parser-to-streamer byte stream plus the streamer's RX payload RAM write port.
interface tcp_vlg_rx_strm_if #(
    parameter int D = 10
);
    import tcp_vlg_pkg::*;

    logic [7:0]   rx_dat;
    logic         rx_val;
    logic         rx_sof;
    logic         rx_eof;
    logic         rx_err;
    tcp_num_t     seg_seq;
    length_t      seg_lng;

    logic [D-1:0] wr_addr;
    logic [7:0]   wr_dat;
    logic         wr_val;

    modport master (
        output rx_dat, rx_val, rx_sof, rx_eof, rx_err, seg_seq, seg_lng,
        input  wr_addr, wr_dat, wr_val
    );

    modport slave (
        input  rx_dat, rx_val, rx_sof, rx_eof, rx_err, seg_seq, seg_lng,
        output wr_addr, wr_dat, wr_val
    );

endinterface

// File: rtl/tcp_vlg_rx_strm.sv
// Writes in-order TCP payload into the RX ring by sequence number and advances
// rem_ack only once a complete, error-free segment has been written.
module tcp_vlg_rx_strm
    import tcp_vlg_pkg::*;
#(
    parameter int D = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                init,
    input  tcp_num_t            init_seq,
    input  tcp_num_t            rd_ptr,
    tcp_vlg_rx_strm_if.slave    rx,
    output tcp_num_t            rem_ack,
    output logic                ack_upd,
    output logic                drop,
    output logic [D:0]          win,
    output logic                idle
);

    rx_strm_state_t state_q, state_d;
    tcp_num_t       rem_ack_q, rem_ack_d;
    tcp_rx_seg_t    seg_q, seg_d;
    logic [16:0]    ctr_q, ctr_d;
    logic [D-1:0]   wr_addr_q, wr_addr_d;
    logic [7:0]     wr_dat_q, wr_dat_d;
    logic           wr_val_q, wr_val_d;
    logic           ack_upd_q, ack_upd_d;
    logic           drop_q, drop_d;
    logic [D:0]     win_q, win_d;

    tcp_num_t       win_full;
    logic           unused_win_hi;
    logic           accept;

    // Free space is the ring size minus unread bytes; only the low D+1 bits matter.
    assign win_full      = (32'd1 << D) - seq_dist(rem_ack_q, rd_ptr);
    assign win_d         = win_full[D:0];
    assign unused_win_hi = &{1'b0, win_full[31:D+1]};

    assign accept = (rx.seg_seq == rem_ack_q)
                 && (rx.seg_lng != '0)
                 && ({16'd0, rx.seg_lng} <= {{(31-D){1'b0}}, win_q});

    always_comb begin
        state_d   = state_q;
        rem_ack_d = rem_ack_q;
        seg_d     = seg_q;
        ctr_d     = ctr_q;
        wr_val_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_dat_d  = wr_dat_q;
        ack_upd_d = 1'b0;
        drop_d    = 1'b0;

        if (init) begin
            state_d   = idle_s;
            rem_ack_d = init_seq;
        end else if (rx.rx_val) begin
            if (rx.rx_sof) begin
                // A new start abandons whatever segment was still open.
                drop_d = (state_q != idle_s) && (seg_q.lng != '0);
                seg_d  = '{seq: rx.seg_seq, lng: rx.seg_lng};
                ctr_d  = 17'd0;
                if (accept) begin
                    wr_val_d  = 1'b1;
                    wr_addr_d = rem_ack_q[D-1:0];
                    wr_dat_d  = rx.rx_dat;
                    ctr_d     = 17'd1;
                    if (rx.rx_eof) begin
                        state_d = idle_s;
                        if (!rx.rx_err && (rx.seg_lng == 16'd1)) begin
                            rem_ack_d = rx.seg_seq + 32'd1;
                            ack_upd_d = 1'b1;
                        end else begin
                            drop_d = 1'b1;
                        end
                    end else begin
                        state_d = strm_s;
                    end
                end else if (rx.rx_eof) begin
                    state_d = idle_s;
                    if (rx.seg_lng != '0) begin
                        drop_d = 1'b1;
                    end
                end else begin
                    state_d = skip_s;
                end
            end else begin
                unique case (state_q)
                    strm_s: begin
                        wr_val_d  = 1'b1;
                        wr_addr_d = rem_ack_q[D-1:0] + ctr_q[D-1:0];
                        wr_dat_d  = rx.rx_dat;
                        ctr_d     = ctr_q + 17'd1;
                        if (rx.rx_eof) begin
                            state_d = idle_s;
                            if (!rx.rx_err && ((ctr_q + 17'd1) == {1'b0, seg_q.lng})) begin
                                rem_ack_d = seg_q.seq + {16'd0, seg_q.lng};
                                ack_upd_d = 1'b1;
                            end else begin
                                drop_d = 1'b1;
                            end
                        end
                    end
                    skip_s: begin
                        if (rx.rx_eof) begin
                            state_d = idle_s;
                            drop_d  = (seg_q.lng != '0);
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= idle_s;
            rem_ack_q <= '0;
            seg_q     <= '0;
            ctr_q     <= '0;
            wr_addr_q <= '0;
            wr_dat_q  <= '0;
            wr_val_q  <= 1'b0;
            ack_upd_q <= 1'b0;
            drop_q    <= 1'b0;
            win_q     <= (D+1)'(1 << D);
        end else begin
            state_q   <= state_d;
            rem_ack_q <= rem_ack_d;
            seg_q     <= seg_d;
            ctr_q     <= ctr_d;
            wr_addr_q <= wr_addr_d;
            wr_dat_q  <= wr_dat_d;
            wr_val_q  <= wr_val_d;
            ack_upd_q <= ack_upd_d;
            drop_q    <= drop_d;
            win_q     <= win_d;
        end
    end

    assign rx.wr_addr = wr_addr_q;
    assign rx.wr_dat  = wr_dat_q;
    assign rx.wr_val  = wr_val_q;
    assign rem_ack    = rem_ack_q;
    assign ack_upd    = ack_upd_q;
    assign drop       = drop_q;
    assign win        = win_q;
    assign idle       = (state_q == idle_s);

endmodule

// File: tb/tb_tcp_vlg_rx_strm.sv
// Scoreboard bench for tcp_vlg_rx_strm: a segment-level model queues expected
// RAM writes and ack/drop events; a monitor compares them as the DUT emits them.
module tb_tcp_vlg_rx_strm;
    import tcp_vlg_pkg::*;

    localparam int D    = 10;
    localparam int RING = 1 << D;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       init = 1'b0;
    tcp_num_t   init_seq = '0;
    tcp_num_t   rd_ptr = '0;
    tcp_num_t   rem_ack;
    logic       ack_upd, drop, idle;
    logic [D:0] win;

    tcp_vlg_rx_strm_if #(.D(D)) bus ();

    tcp_vlg_rx_strm #(.D(D)) dut (
        .clk      (clk),
        .rst      (rst),
        .init     (init),
        .init_seq (init_seq),
        .rd_ptr   (rd_ptr),
        .rx       (bus),
        .rem_ack  (rem_ack),
        .ack_upd  (ack_upd),
        .drop     (drop),
        .win      (win),
        .idle     (idle)
    );

    always #5 clk = ~clk;

    typedef struct { logic [D-1:0] addr; logic [7:0] dat; } wr_exp_t;
    typedef struct { logic [1:0] kind; tcp_num_t ack; } ev_exp_t;  // kind = {ack_upd, drop}

    wr_exp_t wq[$];
    ev_exp_t eq[$];
    wr_exp_t mon_w;
    ev_exp_t mon_e;

    int n_cmp  = 0;
    int n_fail = 0;

    tcp_num_t m_ack = '0;
    bit       pending = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every write and every ack/drop pulse must match the head of its queue.
    always @(negedge clk) begin
        if (rst) begin
            if (bus.wr_val) begin
                check("wr_expected", 64'(wq.size() != 0), 64'd1);
                if (wq.size() != 0) begin
                    mon_w = wq.pop_front();
                    check("wr_addr", 64'(bus.wr_addr), 64'(mon_w.addr));
                    check("wr_dat", 64'(bus.wr_dat), 64'(mon_w.dat));
                end
            end
            if (ack_upd || drop) begin
                check("event_expected", 64'(eq.size() != 0), 64'd1);
                if (eq.size() != 0) begin
                    mon_e = eq.pop_front();
                    check("event_kind", 64'({ack_upd, drop}), 64'(mon_e.kind));
                    check("event_rem_ack", 64'(rem_ack), 64'(mon_e.ack));
                end
            end
        end
    end

    function automatic int m_win();
        tcp_num_t t;
        t = tcp_num_t'(RING) - (m_ack - rd_ptr);
        return int'(t % tcp_num_t'(2 * RING));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic gap();
        repeat (3) tick();
    endtask

    task automatic put_byte(input logic [7:0] d, input bit sof, input bit eof, input bit err,
                            input tcp_num_t seq, input int lng, input bit bub);
        if (bub && ($urandom % 4 == 0)) repeat ($urandom_range(1, 3)) tick();
        bus.rx_val = 1'b1;
        bus.rx_dat = d;
        bus.rx_sof = sof;
        bus.rx_eof = eof;
        bus.rx_err = err;
        if (sof) begin
            bus.seg_seq = seq;
            bus.seg_lng = length_t'(lng);
        end
        tick();
        bus.rx_val = 1'b0;
        bus.rx_sof = 1'b0;
        bus.rx_eof = 1'b0;
        bus.rx_err = 1'b0;
        bus.rx_dat = 8'($urandom);
    endtask

    // Segment-level model: accept rule, expected writes, then the commit/drop outcome.
    task automatic send_seg(input tcp_num_t seq, input int lng, input int n, input bit err,
                            input bit no_eof, input bit bub);
        bit       acc;
        bit       last;
        logic [7:0] d;
        tcp_num_t a;
        if (pending) begin
            eq.push_back('{2'b01, m_ack});
            pending = 1'b0;
        end
        acc = (seq == m_ack) && (lng != 0) && (lng <= m_win());
        for (int i = 0; i < n; i++) begin
            d    = 8'($urandom);
            last = (i == n - 1) && !no_eof;
            if (acc) begin
                a = m_ack + tcp_num_t'(i);
                wq.push_back('{logic'(a % tcp_num_t'(RING)) ? D'(a % tcp_num_t'(RING)) : D'(a % tcp_num_t'(RING)), d});
            end
            if (last) begin
                if (acc && !err && n == lng)
                    eq.push_back('{2'b10, m_ack + tcp_num_t'(lng)});
                else if (lng != 0)
                    eq.push_back('{2'b01, m_ack});
            end
            put_byte(d, i == 0, last, last && err, seq, lng, bub && (i != 0));
        end
        if (no_eof)
            pending = (lng != 0);
        else if (acc && !err && n == lng)
            m_ack = m_ack + tcp_num_t'(lng);
    endtask

    task automatic do_init(input tcp_num_t seq, input tcp_num_t rd);
        init     = 1'b1;
        init_seq = seq;
        rd_ptr   = rd;
        tick();
        init     = 1'b0;
        m_ack    = seq;
        pending  = 1'b0;
        gap();
    endtask

    initial begin
        int       diff, lng, n, k;
        bit       err;
        tcp_num_t seq;

        bus.rx_val = 1'b0; bus.rx_sof = 1'b0; bus.rx_eof = 1'b0; bus.rx_err = 1'b0;
        bus.rx_dat = '0; bus.seg_seq = '0; bus.seg_lng = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_wr_val", 64'(bus.wr_val), 64'd0);
        check("rst_wr_addr", 64'(bus.wr_addr), 64'd0);
        check("rst_wr_dat", 64'(bus.wr_dat), 64'd0);
        check("rst_rem_ack", 64'(rem_ack), 64'd0);
        check("rst_ack_upd", 64'(ack_upd), 64'd0);
        check("rst_drop", 64'(drop), 64'd0);
        check("rst_win", 64'(win), 64'd1024);
        check("rst_idle", 64'(idle), 64'd1);
        rst = 1'b1;
        gap();

        // In-order 100-byte segment.
        do_init(32'h1000, 32'h1000);
        send_seg(32'h1000, 100, 100, 1'b0, 1'b0, 1'b0);
        gap();
        check("t1_rem_ack", 64'(rem_ack), 64'h1064);
        check("t1_idle", 64'(idle), 64'd1);

        // Out-of-order segment is skipped.
        send_seg(32'h2000, 20, 20, 1'b0, 1'b0, 1'b0);
        gap();
        check("t2_rem_ack", 64'(rem_ack), 64'h1064);

        // Checksum error at eof.
        send_seg(m_ack, 50, 50, 1'b1, 1'b0, 1'b0);
        gap();
        check("t3_rem_ack", 64'(rem_ack), 64'h1064);

        // Sequence and ring wrap.
        do_init(32'hFFFF_FFF0, 32'hFFFF_FFF0);
        send_seg(32'hFFFF_FFF0, 64, 64, 1'b0, 1'b0, 1'b0);
        gap();
        check("t4_rem_ack", 64'(rem_ack), 64'h30);
        check("t4_win_busy", 64'(win), 64'd960);
        rd_ptr = 32'h30;
        gap();
        check("t4_win_free", 64'(win), 64'd1024);

        // Window too small, then large enough.
        rd_ptr = m_ack - 32'd1000;
        gap();
        check("t5_win24", 64'(win), 64'd24);
        send_seg(m_ack, 30, 30, 1'b0, 1'b0, 1'b0);
        rd_ptr = rd_ptr + 32'd10;
        gap();
        check("t5_win34", 64'(win), 64'd34);
        send_seg(m_ack, 30, 30, 1'b0, 1'b0, 1'b0);
        gap();
        check("t5_rem_ack", 64'(rem_ack), 64'h4E);

        // Restart mid-segment, then init mid-segment.
        rd_ptr = m_ack;
        gap();
        send_seg(m_ack, 20, 5, 1'b0, 1'b1, 1'b0);
        send_seg(m_ack, 10, 10, 1'b0, 1'b0, 1'b0);
        gap();
        check("t6_rem_ack", 64'(rem_ack), 64'h58);
        send_seg(m_ack, 20, 3, 1'b0, 1'b1, 1'b0);
        do_init(32'h5000, 32'h5000);
        check("t7_rem_ack", 64'(rem_ack), 64'h5000);
        check("t7_idle", 64'(idle), 64'd1);

        // Randomized segments.
        for (int s = 0; s < 150; s++) begin
            diff   = ($urandom % 3 == 0) ? 960 + int'($urandom % 64) : int'($urandom % 1024);
            rd_ptr = m_ack - tcp_num_t'(diff);
            gap();
            check("rnd_win", 64'(win), 64'(m_win()));
            check("rnd_idle", 64'(idle), 64'd1);
            lng = ($urandom % 8 == 0) ? 0 : 1 + int'($urandom % 64);
            seq = ($urandom % 5 == 0) ? m_ack + 32'd1 + tcp_num_t'($urandom % 100) : m_ack;
            n   = (lng == 0) ? 1 : (($urandom % 8 == 0) ? 1 + int'($urandom % 64) : lng);
            err = ($urandom % 8 == 0);
            if (lng != 0 && n >= 2 && ($urandom % 8 == 0)) begin
                k = 1 + int'($urandom % (n - 1));
                send_seg(seq, lng, k, 1'b0, 1'b1, 1'b1);
                lng = 2 + int'($urandom % 30);
                send_seg(m_ack, lng, lng, 1'b0, 1'b0, 1'b1);
            end else begin
                send_seg(seq, lng, n, err, 1'b0, 1'b1);
            end
        end

        for (int i = 0; i < 20 && (wq.size() != 0 || eq.size() != 0); i++) tick();
        gap();
        check("wr_queue_drained", 64'(wq.size()), 64'd0);
        check("ev_queue_drained", 64'(eq.size()), 64'd0);
        check("final_rem_ack", 64'(rem_ack), 64'(m_ack));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
